instr_mem_port: RTL and testbench

INSTR_MEM_PORT -- requirements
Module: instr_mem_port

---
 rtl/instr_mem_port.sv | 104 ++++++++++
 tb/tb_instr_mem_port.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_port.sv
// instr_mem_port: single-port instruction memory with a fetch request/response
// channel and a program-load write channel.
//
// After reset the block spends WORD_QUANTITY cycles filling every word with
// FILL_WORD (INIT), then becomes operational (RUN, init_done=1).
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_addr    fetch request, byte address
//   req_ready             fetch accepted this cycle
//   rsp_valid/rsp_instr   registered fetch response (latency 1)
//   rsp_err               response address was misaligned or out of range
//   rsp_ready             consumer takes the response
//   ld_valid/ld_addr      program-load write, word index
//   ld_data               word to write
//   ld_ready              load accepted this cycle (fetch has priority)
//   init_done             fill complete, block operational
module instr_mem_port #(
    parameter int unsigned WORD_QUANTITY = 256,
    parameter int unsigned INDEX_BITS    = 8,
    parameter logic [31:0] FILL_WORD     = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [31:0]           req_addr,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_instr,
    output logic                  rsp_err,
    input  logic                  rsp_ready,
    input  logic                  ld_valid,
    input  logic [INDEX_BITS-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic                  ld_ready,
    output logic                  init_done
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  state;
    logic [INDEX_BITS-1:0]   counter;
    logic [31:0]             mem [WORD_QUANTITY];

    logic                    req_fire;
    logic                    ld_fire;
    logic                    addr_bad;
    logic [INDEX_BITS-1:0]   req_idx;

    assign req_ready = (state == ST_RUN) && (!rsp_valid || rsp_ready);
    assign req_fire  = req_valid && req_ready;
    // Loads only get the memory port in cycles where no fetch is accepted.
    assign ld_ready  = (state == ST_RUN) && !req_fire;
    assign ld_fire   = ld_valid && ld_ready;
    assign init_done = (state == ST_RUN);

    // Misaligned, or any address bit above the word index range set.
    assign addr_bad  = (req_addr[1:0] != 2'b00) || ((req_addr >> (INDEX_BITS + 2)) != '0);
    assign req_idx   = req_addr[INDEX_BITS+1:2];

    // Memory array kept free of reset so it can map onto block RAM; the INIT
    // fill provides the defined contents after every reset.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[counter] <= FILL_WORD;
        end else if (ld_fire) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            counter   <= '0;
            rsp_valid <= 1'b0;
            rsp_instr <= FILL_WORD;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    rsp_valid <= 1'b0;
                    if (counter == INDEX_BITS'(WORD_QUANTITY - 1)) begin
                        state <= ST_RUN;
                    end
                    counter <= counter + 1'b1;
                end
                ST_RUN: begin
                    if (req_fire) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= addr_bad;
                        rsp_instr <= addr_bad ? FILL_WORD : mem[req_idx];
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_port.sv
// tb_instr_mem_port: directed self-checking bench for instr_mem_port.
module tb_instr_mem_port;

    localparam logic [31:0] FILL = 32'h00000013;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        rsp_ready;
    logic        ld_valid;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    instr_mem_port #(
        .WORD_QUANTITY (256),
        .INDEX_BITS    (8),
        .FILL_WORD     (FILL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Deassert reset and count cycles until init_done rises (bounded).
    task automatic wait_init(input string tag);
        int cycles;
        cycles = 0;
        reset = 1'b0;
        while (!init_done && cycles < 1000) begin
            step();
            cycles++;
        end
        check(tag, 32'(cycles), 32'd256);
    endtask

    task automatic do_load(input string tag, input logic [7:0] a, input logic [31:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        #1;
        check(tag, {31'd0, ld_ready}, 32'd1);
        step();
        ld_valid = 1'b0;
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] a,
                            input logic [31:0] exp_instr, input logic exp_err);
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        check({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        check({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_instr"}, rsp_instr, exp_instr);
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        step();
        check({tag, "_drain"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        repeat (3) step();

        // Reset state
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_instr", rsp_instr, FILL);
        check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_ld_ready",  {31'd0, ld_ready}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);

        wait_init("init_cycles");
        do_fetch("fill_10", 32'h0000_0010, FILL, 1'b0);

        // Load and read-back, error addresses, top-of-range boundary
        do_load("ld5", 8'd5, 32'h00520313);
        do_fetch("f14", 32'h0000_0014, 32'h00520313, 1'b0);
        do_fetch("f15_mis", 32'h0000_0015, FILL, 1'b1);
        do_fetch("f400_oor", 32'h0000_0400, FILL, 1'b1);
        do_load("ld255", 8'd255, 32'hDEADBEEF);
        do_fetch("f3fc", 32'h0000_03FC, 32'hDEADBEEF, 1'b0);
        do_fetch("f80000000", 32'h8000_0000, FILL, 1'b1);

        // Backpressure
        do_load("ld0", 8'd0, 32'h11111111);
        do_load("ld1", 8'd1, 32'h22222222);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        #1;
        check("bp_acc0", {31'd0, req_ready}, 32'd1);
        step();
        req_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rdy", {31'd0, req_ready}, 32'd0);
            check("bp_vld", {31'd0, rsp_valid}, 32'd1);
            check("bp_instr", rsp_instr, 32'h11111111);
            check("bp_err", {31'd0, rsp_err}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_rdy", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        check("bp_rsp4_vld", {31'd0, rsp_valid}, 32'd1);
        check("bp_rsp4", rsp_instr, 32'h22222222);
        step();
        check("bp_drain", {31'd0, rsp_valid}, 32'd0);

        // Fetch priority over load
        req_valid = 1'b1;
        req_addr  = 32'h8;
        ld_valid  = 1'b1;
        ld_addr   = 8'd2;
        ld_data   = 32'h33333333;
        #1;
        check("pri_req_rdy", {31'd0, req_ready}, 32'd1);
        check("pri_ld_rdy", {31'd0, ld_ready}, 32'd0);
        step();
        req_valid = 1'b0;
        #1;
        check("pri_old_word", rsp_instr, FILL);
        check("pri_ld_rdy2", {31'd0, ld_ready}, 32'd1);
        step();
        ld_valid = 1'b0;
        step();
        do_fetch("pri_new_word", 32'h8, 32'h33333333, 1'b0);

        // Streaming 16 consecutive fetches
        for (int i = 0; i < 16; i++) begin
            do_load("st_ld", 8'(i), 32'hA0000000 + 32'(i));
        end
        req_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_addr = 32'(i * 4);
            #1;
            check("st_rdy", {31'd0, req_ready}, 32'd1);
            step();
            check("st_vld", {31'd0, rsp_valid}, 32'd1);
            check("st_instr", rsp_instr, 32'hA0000000 + 32'(i));
        end
        req_valid = 1'b0;
        step();
        check("st_drain", {31'd0, rsp_valid}, 32'd0);

        // Reset mid-INIT at counter=100
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (100) step();
        check("midinit_done", {31'd0, init_done}, 32'd0);
        reset = 1'b1;
        step();
        check("midinit_rst_vld", {31'd0, rsp_valid}, 32'd0);
        wait_init("midinit_cycles");

        // Reset with a pending unconsumed response in RUN
        do_load("ld5b", 8'd5, 32'hCAFEF00D);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h14;
        step();
        req_valid = 1'b0;
        check("pend_vld", {31'd0, rsp_valid}, 32'd1);
        check("pend_instr", rsp_instr, 32'hCAFEF00D);
        reset = 1'b1;
        step();
        check("pend_rst_vld", {31'd0, rsp_valid}, 32'd0);
        check("pend_rst_instr", rsp_instr, FILL);
        check("pend_rst_done", {31'd0, init_done}, 32'd0);
        wait_init("pend_cycles");
        rsp_ready = 1'b1;
        do_fetch("after_rst_f14", 32'h14, FILL, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
